// File: rtl/lcd_text_buffer_arb.sv
// 2x16 character buffer shared by two round-robin writers and a hardware clear
// sequencer; read side is a combinational port for the SC1602 4-bit driver.
module lcd_text_buffer_arb #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_req_a,
  input  logic [4:0] wr_addr_a,
  input  logic [7:0] wr_data_a,
  output logic       wr_ack_a,
  input  logic       wr_req_b,
  input  logic [4:0] wr_addr_b,
  input  logic [7:0] wr_data_b,
  output logic       wr_ack_b,
  input  logic       clr_start,
  output logic       clr_done,
  output logic       busy,
  input  logic [7:0] lcd_addr,
  input  logic       lcd_rd,
  output logic [7:0] lcd_data
);

  // state   | meaning
  // S_IDLE  | arbitrate: pending clear first, then writers
  // S_ACK   | one-cycle ack of the write committed on entry
  // S_CLEAR | write FILL_CHAR to one entry per cycle, index 0..31
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_CLEAR} state_t;

  state_t     state, state_nxt;
  logic [7:0] mem [32];
  logic [4:0] clr_idx, clr_idx_nxt;
  logic       last_b, last_b_nxt;
  logic       clr_pend, clr_pend_nxt;
  logic       grant_b;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic       ack_a_nxt, ack_b_nxt, done_nxt;
  logic       unused_rd;

  // Reads do not depend on the strobe; the driver only needs stable data.
  assign unused_rd = lcd_rd;

  always_comb begin
    state_nxt    = state;
    clr_idx_nxt  = clr_idx;
    last_b_nxt   = last_b;
    clr_pend_nxt = clr_pend;
    grant_b      = 1'b0;
    we           = 1'b0;
    waddr        = wr_addr_a;
    wdata        = wr_data_a;
    ack_a_nxt    = 1'b0;
    ack_b_nxt    = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_pend || clr_start) begin
          state_nxt    = S_CLEAR;
          clr_idx_nxt  = 5'd0;
          clr_pend_nxt = 1'b0;
        end else if (wr_req_a || wr_req_b) begin
          // on a tie, the requester not granted last time wins
          grant_b    = wr_req_b && (!wr_req_a || !last_b);
          we         = 1'b1;
          waddr      = grant_b ? wr_addr_b : wr_addr_a;
          wdata      = grant_b ? wr_data_b : wr_data_a;
          last_b_nxt = grant_b;
          ack_a_nxt  = !grant_b;
          ack_b_nxt  = grant_b;
          state_nxt  = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
        if (clr_start) clr_pend_nxt = 1'b1;
      end
      S_CLEAR: begin
        we          = 1'b1;
        waddr       = clr_idx;
        wdata       = FILL_CHAR;
        clr_idx_nxt = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      clr_idx  <= 5'd0;
      last_b   <= 1'b1;
      clr_pend <= 1'b0;
      wr_ack_a <= 1'b0;
      wr_ack_b <= 1'b0;
      clr_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_idx  <= clr_idx_nxt;
      last_b   <= last_b_nxt;
      clr_pend <= clr_pend_nxt;
      wr_ack_a <= ack_a_nxt;
      wr_ack_b <= ack_b_nxt;
      clr_done <= done_nxt;
      busy     <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= FILL_CHAR;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DDRAM-style address: bit6 = line, [3:0] = column; anything else shows blank
  assign lcd_data = (lcd_addr[7] || lcd_addr[5] || lcd_addr[4]) ? FILL_CHAR
                  : mem[{lcd_addr[6], lcd_addr[3:0]}];

endmodule
